// File: rtl/tone_pkg.sv
// Shared definitions for the tone player: pitch table, song table,
// autoplay state encoding and divisor limits.
package tone_pkg;

    // Smallest half-period the divider will ever run with.
    localparam int MIN_DIV = 2;

    // Number of entries actually stored in the song table.
    localparam int SONG_TAB_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // One song step: note index (0 = rest) and length in beats (1..4).
    typedef struct packed {
        logic [3:0] note;
        logic [2:0] len;
    } song_step_t;

    // Half-period in clk cycles for note 1..8; anything else returns 0
    // and is lifted to MIN_DIV by the divider clamp.
    function automatic logic [15:0] half_period(input logic [31:0] note);
        logic [15:0] hp;
        case (note)
            32'd1:   hp = 16'd190;
            32'd2:   hp = 16'd170;
            32'd3:   hp = 16'd152;
            32'd4:   hp = 16'd143;
            32'd5:   hp = 16'd128;
            32'd6:   hp = 16'd114;
            32'd7:   hp = 16'd101;
            32'd8:   hp = 16'd96;
            default: hp = 16'd0;
        endcase
        return hp;
    endfunction

    // Melody: an ascending scale at one beat per note, then descending at
    // two beats per note. Steps past the table are one-beat rests.
    function automatic song_step_t song_table(input logic [31:0] step);
        song_step_t e;
        case (step)
            32'd0:   e = {4'd1, 3'd1};
            32'd1:   e = {4'd2, 3'd1};
            32'd2:   e = {4'd3, 3'd1};
            32'd3:   e = {4'd4, 3'd1};
            32'd4:   e = {4'd5, 3'd1};
            32'd5:   e = {4'd6, 3'd1};
            32'd6:   e = {4'd7, 3'd1};
            32'd7:   e = {4'd8, 3'd1};
            32'd8:   e = {4'd8, 3'd2};
            32'd9:   e = {4'd7, 3'd2};
            32'd10:  e = {4'd6, 3'd2};
            32'd11:  e = {4'd5, 3'd2};
            32'd12:  e = {4'd4, 3'd2};
            32'd13:  e = {4'd3, 3'd2};
            32'd14:  e = {4'd2, 3'd2};
            32'd15:  e = {4'd1, 3'd2};
            default: e = {4'd0, 3'd1};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/tone_player_if.sv
// Control/status bundle between the key/sequencer side and the tone player.
interface tone_player_if #(
    parameter int NUM_KEYS = 8,
    parameter int IDX_W    = $clog2(NUM_KEYS + 1)
) ();

    logic [NUM_KEYS-1:0] keys;
    logic                mode;
    logic [1:0]          octave;
    logic                play_start;
    logic                speaker;
    logic [IDX_W-1:0]    note_idx;
    logic                busy;
    logic                song_done;

    // Driver side: switches, mode select and start pulse.
    modport master (
        output keys, mode, octave, play_start,
        input  speaker, note_idx, busy, song_done
    );

    // Tone player side.
    modport slave (
        input  keys, mode, octave, play_start,
        output speaker, note_idx, busy, song_done
    );

endinterface

// File: rtl/tone_player_song_rom.sv
// Combinational song ROM: step number -> {note, length in beats}.
module song_rom import tone_pkg::*; #(
    parameter int STEP_W = 4
) (
    input  logic [STEP_W-1:0] i_step,
    output song_step_t        o_entry
);

    // Plain table lookup, no state.
    always_comb begin
        o_entry = song_table(32'(i_step));
    end

endmodule

// File: rtl/tone_player.sv
// Tone player: priority key encoder, glitch-free square-wave divider with
// octave shift, and an autoplay sequencer stepping through the song ROM.
module tone_player import tone_pkg::*; #(
    parameter int NUM_KEYS = 8,
    parameter int DIV_W    = 16,
    parameter int BEAT_DIV = 10000,
    parameter int SONG_LEN = 16,
    parameter int IDX_W    = $clog2(NUM_KEYS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    tone_player_if.slave  bus
);

    localparam int STEP_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int BEAT_W = $clog2(BEAT_DIV + 1);

    fsm_state_t        r_state, w_state_nx;
    logic [STEP_W-1:0] r_step, w_step_nx;
    logic [BEAT_W-1:0] r_tick_cnt, w_tick_cnt_nx;
    logic [2:0]        r_beats, w_beats_nx;
    song_step_t        w_rom_cur, w_rom_nx;

    logic [IDX_W-1:0]  w_key_idx, w_note_nx, r_note_idx;
    logic [DIV_W-1:0]  w_div_raw, w_div, r_div_lat, r_cnt;
    logic              r_speaker, r_busy, r_song_done;

    // Length of the step in progress decides when to advance.
    song_rom #(.STEP_W(STEP_W)) u_rom_cur (
        .i_step  (r_step),
        .o_entry (w_rom_cur)
    );

    // Note of the step about to be entered, so note_idx moves with the step.
    song_rom #(.STEP_W(STEP_W)) u_rom_nx (
        .i_step  (w_step_nx),
        .o_entry (w_rom_nx)
    );

    // Priority encoder: lowest asserted key wins, no key means rest.
    always_comb begin
        w_key_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (bus.keys[i]) begin
                w_key_idx = IDX_W'(i + 1);
            end else begin
                w_key_idx = w_key_idx;
            end
        end
    end

    // Autoplay next-state logic: beat timing, step advance, abort/restart.
    always_comb begin
        w_state_nx    = r_state;
        w_step_nx     = r_step;
        w_tick_cnt_nx = r_tick_cnt;
        w_beats_nx    = r_beats;
        case (r_state)
            ST_IDLE: begin
                if (bus.mode && bus.play_start) begin
                    w_state_nx    = ST_PLAY;
                    w_step_nx     = '0;
                    w_tick_cnt_nx = '0;
                    w_beats_nx    = 3'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (!bus.mode) begin
                    // Leaving autoplay abandons the song silently.
                    w_state_nx    = ST_IDLE;
                    w_step_nx     = '0;
                    w_tick_cnt_nx = '0;
                    w_beats_nx    = 3'd0;
                end else if (bus.play_start) begin
                    w_step_nx     = '0;
                    w_tick_cnt_nx = '0;
                    w_beats_nx    = 3'd0;
                end else if (r_tick_cnt == BEAT_W'(BEAT_DIV - 1)) begin
                    w_tick_cnt_nx = '0;
                    if ((r_beats + 3'd1) >= w_rom_cur.len) begin
                        w_beats_nx = 3'd0;
                        if (r_step == STEP_W'(SONG_LEN - 1)) begin
                            w_state_nx = ST_DONE;
                            w_step_nx  = '0;
                        end else begin
                            w_step_nx = r_step + STEP_W'(1);
                        end
                    end else begin
                        w_beats_nx = r_beats + 3'd1;
                    end
                end else begin
                    w_tick_cnt_nx = r_tick_cnt + BEAT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.mode && bus.play_start) begin
                    w_state_nx    = ST_PLAY;
                    w_step_nx     = '0;
                    w_tick_cnt_nx = '0;
                    w_beats_nx    = 3'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx    = ST_IDLE;
                w_step_nx     = '0;
                w_tick_cnt_nx = '0;
                w_beats_nx    = 3'd0;
            end
        endcase
    end

    // Sounding note for the next cycle: song note while playing, otherwise
    // live keys in key mode and silence in autoplay mode.
    always_comb begin
        if (w_state_nx == ST_PLAY) begin
            w_note_nx = IDX_W'(w_rom_nx.note);
        end else if ((w_state_nx == ST_DONE) || bus.mode) begin
            w_note_nx = '0;
        end else begin
            w_note_nx = w_key_idx;
        end
    end

    // Divisor for the requested note, octave-shifted and clamped; 0 = rest.
    always_comb begin
        w_div_raw = DIV_W'(half_period(32'(w_note_nx))) >> bus.octave;
        if (w_note_nx == '0) begin
            w_div = '0;
        end else if (w_div_raw < DIV_W'(MIN_DIV)) begin
            w_div = DIV_W'(MIN_DIV);
        end else begin
            w_div = w_div_raw;
        end
    end

    // Autoplay state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_tick_cnt <= '0;
            r_beats    <= 3'd0;
        end else begin
            r_state    <= w_state_nx;
            r_step     <= w_step_nx;
            r_tick_cnt <= w_tick_cnt_nx;
            r_beats    <= w_beats_nx;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_note_idx  <= '0;
            r_busy      <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_note_idx  <= w_note_nx;
            r_busy      <= (w_state_nx == ST_PLAY);
            r_song_done <= (w_state_nx == ST_DONE);
        end
    end

    // Square-wave divider: a new divisor is only taken at a toggle or from
    // rest, so the half-period in progress always finishes unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_speaker <= 1'b0;
            r_cnt     <= '0;
            r_div_lat <= '0;
        end else if (w_note_nx == '0) begin
            r_speaker <= 1'b0;
            r_cnt     <= '0;
            r_div_lat <= '0;
        end else if (r_div_lat == '0) begin
            r_cnt     <= '0;
            r_div_lat <= w_div;
        end else if (r_cnt == (r_div_lat - DIV_W'(1))) begin
            r_speaker <= ~r_speaker;
            r_cnt     <= '0;
            r_div_lat <= w_div;
        end else begin
            r_cnt     <= r_cnt + DIV_W'(1);
        end
    end

    assign bus.speaker   = r_speaker;
    assign bus.note_idx  = r_note_idx;
    assign bus.busy      = r_busy;
    assign bus.song_done = r_song_done;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player: live keys, octave, rests, autoplay,
// abort/restart and asynchronous reset.
module tb_tone_player;

    logic clk = 1'b0;
    logic reset;

    tone_player_if #(.NUM_KEYS(8), .IDX_W(4)) bus ();

    tone_player #(
        .NUM_KEYS (8),
        .DIV_W    (16),
        .BEAT_DIV (10),
        .SONG_LEN (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n;
    int bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles until speaker changes, -1 if it never does within the bound.
    task automatic wait_toggle(output int cycles);
        logic s0;
        logic done;
        s0     = bus.speaker;
        done   = 1'b0;
        cycles = -1;
        for (int i = 1; i <= 2000; i++) begin
            if (!done) begin
                @(negedge clk);
                if (bus.speaker !== s0) begin
                    done   = 1'b1;
                    cycles = i;
                end
            end
        end
    endtask

    // Count cycles where anything is not silent/idle.
    task automatic quiet(input int ncyc, output int bad_cycles);
        bad_cycles = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.speaker !== 1'b0 || bus.note_idx !== 4'd0 ||
                bus.busy !== 1'b0 || bus.song_done !== 1'b0) begin
                bad_cycles++;
            end
        end
    endtask

    task automatic start_song();
        bus.play_start = 1'b1;
        @(negedge clk);
        bus.play_start = 1'b0;
    endtask

    // Expected note c cycles into the song: 1..8 for 10 cycles each,
    // then 8..1 for 20 cycles each.
    function automatic int exp_note(input int c);
        if (c < 80) return c / 10 + 1;
        else        return 8 - (c - 80) / 20;
    endfunction

    // Called at the first cycle of a song; ends one cycle after song_done.
    task automatic check_song();
        int bad_st;
        bad_st = 0;
        for (int c = 0; c < 240; c++) begin
            check("song_note", 32'(bus.note_idx), exp_note(c));
            if (bus.busy !== 1'b1 || bus.song_done !== 1'b0) bad_st++;
            @(negedge clk);
        end
        check("song_busy_during", bad_st, 0);
        check("song_done_pulse", 32'(bus.song_done), 1);
        check("song_busy_end", 32'(bus.busy), 0);
        check("song_note_end", 32'(bus.note_idx), 0);
        @(negedge clk);
        check("song_done_once", 32'(bus.song_done), 0);
        check("song_busy_after", 32'(bus.busy), 0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.keys       = 8'h00;
        bus.mode       = 1'b0;
        bus.octave     = 2'd0;
        bus.play_start = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_speaker", 32'(bus.speaker), 0);
        check("rst_note", 32'(bus.note_idx), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.song_done), 0);
        reset = 1'b0;
        quiet(200, bad);
        check("idle_quiet", bad, 0);

        // Live note 1, then switch to note 8 mid half-period.
        bus.keys = 8'h01;
        @(negedge clk);
        check("live_note1", 32'(bus.note_idx), 1);
        wait_toggle(n);
        check("note1_first_rise", n, 190);
        check("note1_high", 32'(bus.speaker), 1);
        wait_toggle(n);
        check("note1_half", n, 190);
        repeat (50) @(negedge clk);
        bus.keys = 8'h80;
        @(negedge clk);
        check("note8_idx", 32'(bus.note_idx), 8);
        wait_toggle(n);
        check("old_half_completes", n, 139);
        wait_toggle(n);
        check("note8_half_a", n, 96);
        wait_toggle(n);
        check("note8_half_b", n, 96);
        check("note8_high", 32'(bus.speaker), 1);

        // Rest forces speaker low next cycle.
        bus.keys = 8'h00;
        @(negedge clk);
        check("rest_speaker", 32'(bus.speaker), 0);
        check("rest_note", 32'(bus.note_idx), 0);
        quiet(1000, bad);
        check("rest_quiet", bad, 0);

        // Priority encoding and octave change mid-note.
        bus.keys = 8'b0001_0010;
        @(negedge clk);
        check("prio_note2", 32'(bus.note_idx), 2);
        wait_toggle(n);
        check("note2_first_rise", n, 170);
        repeat (20) @(negedge clk);
        bus.octave = 2'd2;
        wait_toggle(n);
        check("octave_old_half", n, 150);
        wait_toggle(n);
        check("octave_half_a", n, 42);
        wait_toggle(n);
        check("octave_half_b", n, 42);
        bus.keys   = 8'h00;
        bus.octave = 2'd0;
        @(negedge clk);
        check("rest2_speaker", 32'(bus.speaker), 0);

        // Autoplay full song; keys are ignored.
        bus.keys = 8'h40;
        bus.mode = 1'b1;
        @(negedge clk);
        check("auto_idle_ignores_keys", 32'(bus.note_idx), 0);
        start_song();
        check("song_busy_start", 32'(bus.busy), 1);
        check_song();

        // Abort by leaving autoplay at step 5.
        start_song();
        repeat (52) @(negedge clk);
        check("abort_step5_note", 32'(bus.note_idx), 6);
        bus.mode = 1'b0;
        bus.keys = 8'h04;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_note_live", 32'(bus.note_idx), 3);
        check("abort_no_done", 32'(bus.song_done), 0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.song_done !== 1'b0 || bus.busy !== 1'b0 || bus.note_idx !== 4'd3) bad++;
        end
        check("abort_stays_live", bad, 0);

        // Restart at step 10 replays the whole song.
        bus.keys = 8'h00;
        bus.mode = 1'b1;
        @(negedge clk);
        start_song();
        repeat (125) @(negedge clk);
        check("restart_step10_note", 32'(bus.note_idx), 6);
        start_song();
        check("restart_busy", 32'(bus.busy), 1);
        check_song();

        // Asynchronous reset in the middle of a note.
        bus.mode = 1'b0;
        bus.keys = 8'h01;
        @(negedge clk);
        wait_toggle(n);
        check("pre_reset_rise", n, 190);
        repeat (10) @(negedge clk);
        check("pre_reset_high", 32'(bus.speaker), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_note_speaker", 32'(bus.speaker), 0);
        check("arst_note_idx", 32'(bus.note_idx), 0);
        bus.keys = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet(300, bad);
        check("post_reset_quiet_a", bad, 0);

        // Asynchronous reset in the middle of a song.
        bus.mode = 1'b1;
        start_song();
        repeat (30) @(negedge clk);
        check("mid_song_busy", 32'(bus.busy), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_song_busy", 32'(bus.busy), 0);
        check("arst_song_note", 32'(bus.note_idx), 0);
        check("arst_song_speaker", 32'(bus.speaker), 0);
        check("arst_song_done", 32'(bus.song_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet(300, bad);
        check("post_reset_quiet_b", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
Parametrised tone generator for the keyboard/speaker lab board. It replaces the fixed 8-key square-wave divider with a generalised version that adds:
- N keys with priority encoding
- octave shift
- glitch-free note changes
- explicit rest handling
- an autoplay sequencer that plays a melody stored in a small song ROM

It sits between the debounced key switches and the speaker pin.

Parameters:
NUM_KEYS, 8, number of key inputs / notes in the pitch table
DIV_W, 16, width of half-period counter and divisor values
BEAT_DIV, 10000, clk cycles per beat tick in autoplay
SONG_LEN, 16, number of steps in the song ROM
IDX_W, $clog2(NUM_KEYS+1), width of note index (0 = rest, 1..NUM_KEYS = note)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
keys  in  NUM_KEYS  key switches; keys[0] = lowest note, highest priority
mode  in  1  0 = live keys, 1 = autoplay
octave  in  2  divisor right-shift (0..3), raises pitch by 2^octave
play_start  in  1  one-cycle pulse; starts/restarts song when mode=1
speaker  out  1  square-wave output
note_idx  out  IDX_W  note currently sounding (0 = rest)
busy  out  1  high while the song is playing
song_done  out  1  one-cycle pulse after the last step completes

Behaviour:
- Reset (async, active-high): speaker=0, note_idx=0, busy=0, song_done=0; all counters 0; FSM IDLE; latched divisor 0.
- Live mode (mode=0):
  - keys registered once.
  - Requested note = lowest asserted index i, giving idx i+1; no key gives 0.
  - note_idx updates 1 cycle after keys change.
- Divisor: div = HALF_PERIOD[idx-1] >> octave, clamped to minimum 2; unsigned DIV_W arithmetic.
- Tone counter:
  - Counts 0..div_lat-1.
  - At div_lat-1: toggle speaker, counter returns to 0.
  - Half-period = div_lat cycles.
- Glitch-free change: a new div is latched into div_lat only at a toggle event, or immediately when currently resting. The half-period in progress always completes with the old divisor.
- Rest (idx=0):
  - Takes effect on the next cycle: speaker forced 0, counter held 0.
  - Never toggles; a zero divisor must never wrap the counter.
- Rest to note: counter starts at 0; first rising edge of speaker occurs div cycles after note_idx becomes nonzero.
- Autoplay FSM with states IDLE, PLAY, DONE:
  - IDLE: play_start & mode=1 goes to PLAY. step=0, beat counter=0, beat count=0, busy=1.
  - PLAY:
    - Note = rom_note[step]; length = rom_len[step] (1..4 beats).
    - Beat tick every BEAT_DIV cycles.
    - When the beat count reaches the length, advance step.
    - After step SONG_LEN-1, go to DONE.
  - DONE: song_done=1 for exactly one cycle, busy=0, note_idx=0, then IDLE.
- In autoplay, keys are ignored.
- play_start during PLAY restarts from step 0 on the next cycle.
- mode falling to 0 during PLAY aborts to IDLE on the next cycle: busy=0, no song_done, live keys take over.
- play_start with mode=0 is ignored.
- Octave changes follow the same latch-at-toggle rule as note changes.

Decomposition:
- Package tone_pkg holds:
  - the HALF_PERIOD table, with defaults for 8 notes: 190,170,152,143,128,114,101,96
  - the note/length song table: steps 0-7 = notes 1..8 at 1 beat each; steps 8-15 = notes 8..1 at 2 beats each
  - FSM state enum
  - MIN_DIV=2
- Sub-module song_rom: combinational step -> {note, len}.
- tone_player contains the key encoder, divider, and FSM.

Test Plan:
- Live, keys=8'b00000001, octave=0 -> speaker toggles every 190 cycles (period 380); note_idx=1 one cycle after keys applied.
- Live, keys=8'b00010010 -> note_idx=2, half-period 170. Octave=2 applied mid-note -> current half-period finishes at 170, subsequent half-periods 42.
- Live, keys 0x01 -> 0x80 mid half-period -> remaining 190-cycle half completes, then 96-cycle half-periods. keys -> 0 -> speaker 0 next cycle, note_idx=0, no toggles for 1000 cycles.
- Autoplay, BEAT_DIV=10, mode=1, pulse play_start:
  - busy=1
  - note_idx steps 1..8 each for 10 cycles, then 8..1 each for 20 cycles
  - song_done pulses once 240 cycles after start
  - busy=0 afterwards
- Autoplay abort/restart:
  - mode->0 at step 5 -> IDLE next cycle, no song_done, keys followed.
  - play_start at step 10 -> note_idx=1 again and full 240-cycle song replays.
- Reset asserted mid-note and mid-song -> all outputs 0 asynchronously. After release, no toggles until a key or play_start arrives.
